// File: rtl/vjtag_pkg.sv
// vjtag_pkg: shared definitions for the virtual-JTAG command bridge.
//   - vJTAG instruction opcodes (4-bit IR values)
//   - cmd_t: one queued application command {run, test}
package vjtag_pkg;

    localparam logic [3:0] BYPASS      = 4'hF;
    localparam logic [3:0] IDCODE      = 4'h1;
    localparam logic [3:0] READREG     = 4'h2;
    localparam logic [3:0] SETREGISTER = 4'h3;
    localparam logic [3:0] RUNTEST     = 4'h4;
    localparam logic [3:0] STATUS      = 4'h5;
    localparam logic [3:0] SETTEST     = 4'h6;
    localparam logic [3:0] WRITEREG    = 4'h7;
    localparam logic [3:0] READTXT     = 4'h8;
    localparam logic [3:0] SETTXTIDX   = 4'h9;
    localparam logic [3:0] WRITETXT    = 4'hA;
    localparam logic [3:0] RESETHI     = 4'hB;
    localparam logic [3:0] RESETLO     = 4'hC;
    localparam logic [3:0] SELTEST     = 4'hE;

    typedef struct packed {
        logic       run;   // 1 = RUNTEST, 0 = SELTEST
        logic [3:0] test;
    } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: first-word fall-through command queue with synchronous flush.
// Ports:
//   clk, areset     system clock, async active-high reset
//   push, din       enqueue request and entry
//   accept          push was taken this cycle (a pop frees room when full)
//   pop             dequeue request (ignored when empty)
//   flush           drop all contents
//   valid, dout     head entry
//   full, level     occupancy status
module cmd_fifo
    import vjtag_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic                     push,
    input  cmd_t                     din,
    output logic                     accept,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     valid,
    output cmd_t                     dout,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    cmd_t          mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          do_pop;

    assign level  = wr_ptr - rd_ptr;
    assign full   = (level == (AW+1)'(DEPTH));
    assign valid  = (level != '0);
    assign dout   = mem[rd_ptr[AW-1:0]];
    assign do_pop = pop & valid;
    // Pop is applied first, so a full FIFO still takes a push when popped.
    assign accept = push & (~full | do_pop);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/vjtag_cmd_bridge.sv
// vjtag_cmd_bridge: virtual-JTAG endpoint running in the clk domain.
// Oversamples the vJTAG TAP signals, decodes IR/DR operations, owns a
// register file and text buffer, and queues RUNTEST/SELTEST commands.
// Ports:
//   clk, areset                        system clock, async active-high reset
//   tck, tdi, ir_in, v_cdr/sdr/udr/uir vJTAG inputs (asynchronous)
//   tdo                                vJTAG data out (registered)
//   app_rst_n                          application soft reset, active low
//   cmd_valid/run/test, cmd_ready      command queue head, FWFT
//   app_rd_addr, app_rd_data           register read, 1-cycle latency
//   app_wr_en/addr/data                register write
//   overflow, cmd_count                sticky drop flag, accepted commands
module vjtag_cmd_bridge
    import vjtag_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          NUM_REGS   = 8,
    parameter int          TXT_DEPTH  = 32,
    parameter int          CMD_DEPTH  = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h100011d3
) (
    input  logic                        clk,
    input  logic                        areset,
    input  logic                        tck,
    input  logic                        tdi,
    input  logic [3:0]                  ir_in,
    input  logic                        v_cdr,
    input  logic                        v_sdr,
    input  logic                        v_udr,
    input  logic                        v_uir,
    output logic                        tdo,
    output logic                        app_rst_n,
    output logic                        cmd_valid,
    output logic                        cmd_run,
    output logic [3:0]                  cmd_test,
    input  logic                        cmd_ready,
    input  logic [$clog2(NUM_REGS)-1:0] app_rd_addr,
    output logic [DATA_W-1:0]           app_rd_data,
    input  logic                        app_wr_en,
    input  logic [$clog2(NUM_REGS)-1:0] app_wr_addr,
    input  logic [DATA_W-1:0]           app_wr_data,
    output logic                        overflow,
    output logic [7:0]                  cmd_count
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int TW = $clog2(TXT_DEPTH);
    localparam int LW = $clog2(CMD_DEPTH) + 1;

    // Two-stage synchroniser over all TAP inputs, then edge history.
    logic [9:0] sy0, sy1;
    logic       tck_s, tdi_s, cdr_s, sdr_s, udr_s, uir_s;
    logic [3:0] ir_s;
    logic       tck_s_q, udr_s_q, uir_s_q;
    logic       tck_rise, udr_rise, uir_rise;

    assign {ir_s, uir_s, udr_s, sdr_s, cdr_s, tdi_s, tck_s} = sy1;
    assign tck_rise = tck_s & ~tck_s_q;
    assign udr_rise = udr_s & ~udr_s_q;
    assign uir_rise = uir_s & ~uir_s_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            sy0     <= '0;
            sy1     <= '0;
            tck_s_q <= 1'b0;
            udr_s_q <= 1'b0;
            uir_s_q <= 1'b0;
        end else begin
            sy0     <= {ir_in, v_uir, v_udr, v_sdr, v_cdr, tdi, tck};
            sy1     <= sy0;
            tck_s_q <= tck_s;
            udr_s_q <= udr_s;
            uir_s_q <= uir_s;
        end
    end

    logic [3:0]        opcode;
    logic [DATA_W-1:0] shift;
    logic [AW-1:0]     reg_idx;
    logic [TW-1:0]     txt_idx;
    logic [3:0]        test_buf;
    logic              tdo_upd;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [7:0]        text [TXT_DEPTH];

    logic capture, shifting, jtag_wr;
    assign capture  = tck_rise & cdr_s;
    assign shifting = tck_rise & sdr_s;
    assign jtag_wr  = udr_rise & (opcode == WRITEREG);

    // Command queue
    logic          fifo_push, fifo_accept, fifo_flush, fifo_full;
    logic [LW-1:0] fifo_level;
    cmd_t          fifo_din, fifo_dout;

    assign fifo_push  = udr_rise & ((opcode == RUNTEST) | (opcode == SELTEST));
    assign fifo_flush = uir_rise & (ir_s == RESETLO);
    assign fifo_din   = '{run: (opcode == RUNTEST), test: test_buf};
    assign cmd_run    = fifo_dout.run;
    assign cmd_test   = fifo_dout.test;

    cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .clk    (clk),
        .areset (areset),
        .push   (fifo_push),
        .din    (fifo_din),
        .accept (fifo_accept),
        .pop    (cmd_ready),
        .flush  (fifo_flush),
        .valid  (cmd_valid),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .level  (fifo_level)
    );

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            opcode      <= '0;
            shift       <= '0;
            reg_idx     <= '0;
            txt_idx     <= '0;
            test_buf    <= '0;
            tdo         <= 1'b0;
            tdo_upd     <= 1'b0;
            app_rst_n   <= 1'b1;
            overflow    <= 1'b0;
            cmd_count   <= '0;
            app_rd_data <= '0;
            for (int i = 0; i < NUM_REGS; i++)  regs[i] <= '0;
            for (int i = 0; i < TXT_DEPTH; i++) text[i] <= '0;
        end else begin
            // tdo follows the shift register one clk after it moves
            tdo_upd <= capture | shifting;
            if (tdo_upd) tdo <= (opcode == BYPASS) ? tdi_s : shift[0];

            if (uir_rise) begin
                opcode <= ir_s;
                if (ir_s == RESETLO) app_rst_n <= 1'b0;
                if (ir_s == RESETHI) app_rst_n <= 1'b1;
            end

            if (capture) begin
                case (opcode)
                    IDCODE:  shift <= DATA_W'(IDCODE_VAL);
                    READREG: shift <= regs[reg_idx];
                    READTXT: begin
                        shift   <= DATA_W'(text[txt_idx]);
                        txt_idx <= txt_idx + 1'b1;
                    end
                    STATUS:  shift <= DATA_W'({fifo_level, overflow, app_rst_n, cmd_count});
                    default: ;
                endcase
            end else if (shifting) begin
                shift <= {tdi_s, shift[DATA_W-1:1]};
            end

            if (udr_rise) begin
                case (opcode)
                    SETREGISTER: if (shift < DATA_W'(NUM_REGS)) reg_idx <= shift[AW-1:0];
                    SETTXTIDX:   txt_idx <= shift[TW-1:0];
                    WRITETXT: begin
                        text[txt_idx] <= shift[7:0];
                        txt_idx       <= txt_idx + 1'b1;
                    end
                    SETTEST:     test_buf <= shift[3:0];
                    default: ;
                endcase
            end

            // JTAG write takes priority over an app write to the same index.
            for (int i = 0; i < NUM_REGS; i++) begin
                if (jtag_wr && reg_idx == AW'(i))
                    regs[i] <= shift;
                else if (app_wr_en && app_wr_addr == AW'(i))
                    regs[i] <= app_wr_data;
            end
            app_rd_data <= regs[app_rd_addr];

            // Set after clear: a drop coinciding with a STATUS read stays visible.
            if (capture && opcode == STATUS) overflow <= 1'b0;
            if (fifo_push && !fifo_accept)   overflow <= 1'b1;
            if (fifo_accept)                 cmd_count <= cmd_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_vjtag_cmd_bridge.sv
// Directed testbench for vjtag_cmd_bridge: drives TAP sequences slowly
// relative to clk and checks tdo scans, register/text access, the
// command queue, soft reset and asynchronous reset.
module tb_vjtag_cmd_bridge;
    import vjtag_pkg::*;

    logic        clk = 0, areset = 1;
    logic        tck = 0, tdi = 0;
    logic [3:0]  ir_in = 0;
    logic        v_cdr = 0, v_sdr = 0, v_udr = 0, v_uir = 0;
    logic        tdo, app_rst_n, cmd_valid, cmd_run, overflow;
    logic [3:0]  cmd_test;
    logic        cmd_ready = 0;
    logic [2:0]  app_rd_addr = 0, app_wr_addr = 0;
    logic [31:0] app_rd_data, app_wr_data = 0;
    logic        app_wr_en = 0;
    logic [7:0]  cmd_count;

    int errors = 0, checks = 0;
    logic [31:0] rd;

    vjtag_cmd_bridge dut (
        .clk(clk), .areset(areset), .tck(tck), .tdi(tdi), .ir_in(ir_in),
        .v_cdr(v_cdr), .v_sdr(v_sdr), .v_udr(v_udr), .v_uir(v_uir),
        .tdo(tdo), .app_rst_n(app_rst_n), .cmd_valid(cmd_valid),
        .cmd_run(cmd_run), .cmd_test(cmd_test), .cmd_ready(cmd_ready),
        .app_rd_addr(app_rd_addr), .app_rd_data(app_rd_data),
        .app_wr_en(app_wr_en), .app_wr_addr(app_wr_addr),
        .app_wr_data(app_wr_data), .overflow(overflow), .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tck_pulse();
        tck = 1; clks(4);
        tck = 0; clks(4);
    endtask

    task automatic ir_load(input logic [3:0] op);
        ir_in = op; clks(3);
        v_uir = 1; clks(4);
        v_uir = 0; clks(3);
    endtask

    task automatic shift_bit(input logic b);
        tdi = b; v_sdr = 1; clks(2);
        tck_pulse();
    endtask

    task automatic dr_write(input logic [3:0] op, input logic [31:0] d);
        ir_load(op);
        for (int i = 0; i < 32; i++) shift_bit(d[i]);
        v_sdr = 0; tdi = 0; clks(2);
        v_udr = 1; clks(4);
        v_udr = 0; clks(4);
    endtask

    task automatic dr_read(input logic [3:0] op, output logic [31:0] d);
        ir_load(op);
        v_cdr = 1; clks(2);
        tck_pulse();
        v_cdr = 0;
        d[0] = tdo;
        for (int i = 1; i < 32; i++) begin
            shift_bit(1'b0);
            d[i] = tdo;
        end
        v_sdr = 0; clks(2);
    endtask

    task automatic test_reset();
        clks(3);
        checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL reset_tdo got=%b exp=0", tdo); end
        checks++; if (app_rst_n !== 1'b1) begin errors++; $display("FAIL reset_app_rst_n got=%b exp=1", app_rst_n); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid got=%b exp=0", cmd_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (cmd_count !== 8'd0) begin errors++; $display("FAIL reset_cmd_count got=%0d exp=0", cmd_count); end
        checks++; if (app_rd_data !== 32'd0) begin errors++; $display("FAIL reset_app_rd_data got=%h exp=0", app_rd_data); end
        areset = 0; clks(3);
    endtask

    task automatic test_idcode(input string tag);
        dr_read(IDCODE, rd);
        checks++; if (rd !== 32'h100011d3) begin errors++; $display("FAIL %s got=%h exp=100011d3", tag, rd); end
    endtask

    task automatic test_regs();
        dr_write(SETREGISTER, 32'd5);
        dr_write(WRITEREG, 32'hDEADBEEF);
        app_rd_addr = 5; clks(1);
        checks++; if (app_rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL app_rd_5 got=%h exp=deadbeef", app_rd_data); end
        app_rd_addr = 0; clks(1);
        checks++; if (app_rd_data !== 32'd0) begin errors++; $display("FAIL app_rd_0 got=%h exp=0", app_rd_data); end
        // out-of-range index must be ignored: index stays 5
        dr_write(SETREGISTER, 32'd9);
        dr_read(READREG, rd);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL jtag_readreg got=%h exp=deadbeef", rd); end
        // application write, seen over JTAG
        app_wr_addr = 2; app_wr_data = 32'h12345678; app_wr_en = 1; clks(1);
        app_wr_en = 0;
        dr_write(SETREGISTER, 32'd2);
        dr_read(READREG, rd);
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL app_write_jtag_read got=%h exp=12345678", rd); end
    endtask

    task automatic test_text();
        dr_write(SETTXTIDX, 32'd31);
        dr_write(WRITETXT, 32'h41);
        dr_write(WRITETXT, 32'h42);
        dr_write(SETTXTIDX, 32'd31);
        dr_read(READTXT, rd);
        checks++; if (rd !== 32'h41) begin errors++; $display("FAIL text31 got=%h exp=41", rd); end
        dr_read(READTXT, rd);
        checks++; if (rd !== 32'h42) begin errors++; $display("FAIL text0_wrap got=%h exp=42", rd); end
    endtask

    task automatic test_overflow();
        dr_write(SETTEST, 32'd3);
        for (int i = 0; i < 5; i++) dr_write(RUNTEST, 32'd0);
        checks++; if ({cmd_valid, cmd_run, cmd_test} !== 6'b1_1_0011) begin errors++; $display("FAIL fifo_head got=%b exp=110011", {cmd_valid, cmd_run, cmd_test}); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got=%b exp=1", overflow); end
        checks++; if (cmd_count !== 8'd4) begin errors++; $display("FAIL cmd_count4 got=%0d exp=4", cmd_count); end
        // level 4, overflow 1, app_rst_n 1, count 4
        dr_read(STATUS, rd);
        checks++; if (rd !== 32'h0000_1304) begin errors++; $display("FAIL status got=%h exp=00001304", rd); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear got=%b exp=0", overflow); end
        cmd_ready = 1; clks(4); cmd_ready = 0;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL fifo_drain got=%b exp=0", cmd_valid); end
        dr_write(SETTEST, 32'd9);
        dr_write(SELTEST, 32'd0);
        checks++; if ({cmd_valid, cmd_run, cmd_test} !== 6'b1_0_1001) begin errors++; $display("FAIL seltest_head got=%b exp=101001", {cmd_valid, cmd_run, cmd_test}); end
        checks++; if (cmd_count !== 8'd5) begin errors++; $display("FAIL cmd_count5 got=%0d exp=5", cmd_count); end
    endtask

    task automatic test_soft_reset();
        ir_load(RESETLO);
        checks++; if (app_rst_n !== 1'b0) begin errors++; $display("FAIL resetlo_rst got=%b exp=0", app_rst_n); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL resetlo_flush got=%b exp=0", cmd_valid); end
        checks++; if (cmd_count !== 8'd5) begin errors++; $display("FAIL flush_count got=%0d exp=5", cmd_count); end
        ir_load(RESETHI);
        checks++; if (app_rst_n !== 1'b1) begin errors++; $display("FAIL resethi_rst got=%b exp=1", app_rst_n); end
    endtask

    task automatic test_areset();
        ir_load(SETREGISTER);
        ir_load(WRITEREG);
        for (int i = 0; i < 16; i++) shift_bit(1'b1);
        areset = 1; clks(2);
        checks++; if ({tdo, app_rst_n, cmd_valid, overflow} !== 4'b0100) begin errors++; $display("FAIL areset_outs got=%b exp=0100", {tdo, app_rst_n, cmd_valid, overflow}); end
        checks++; if (cmd_count !== 8'd0) begin errors++; $display("FAIL areset_count got=%0d exp=0", cmd_count); end
        v_sdr = 0; tdi = 0; areset = 0;
        app_rd_addr = 2; clks(3);
        checks++; if (app_rd_data !== 32'd0) begin errors++; $display("FAIL areset_regs got=%h exp=0", app_rd_data); end
        test_idcode("idcode_after_areset");
    endtask

    initial begin
        test_reset();
        test_idcode("idcode");
        test_regs();
        test_text();
        test_overflow();
        test_soft_reset();
        test_areset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
